// File: rtl/lucid64_pkg.sv
// Shared constants and types for the Lucid64 five-stage pipeline control logic.
package lucid64_pkg;

    localparam int NUM_STAGES = 5;
    localparam int IF_STAGE   = 0;
    localparam int ID_STAGE   = 1;
    localparam int EX_STAGE   = 2;
    localparam int MEM_STAGE  = 3;
    localparam int WB_STAGE   = 4;

    localparam logic REDIR_BRANCH = 1'b0;
    localparam logic REDIR_TRAP   = 1'b1;

    typedef enum logic {
        REDIR_IDLE,
        REDIR_PENDING
    } redir_state_e;

endpackage

// File: rtl/ex_occupancy_counter.sv
// Tracks how long a multi-cycle op has occupied EX and reports when it must keep EX busy.
module ex_occupancy_counter #(
    parameter int MULDIV_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic multicycle_i,
    input  logic mem_stall_i,
    input  logic flush_i,
    output logic busy_o
);

    localparam int CW = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MULDIV_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign busy_o = multicycle_i && (cnt_q != LAST);

    // The count keeps advancing under a MEM stall, then parks at LAST until MEM lets the op leave.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i || !multicycle_i) begin
            cnt_d = '0;
        end else if (busy_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!mem_stall_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Hazard controller for the Lucid64 pipeline: per-stage stall/squash/bubble strobes and PC redirect sequencing.
module pipeline_controller
    import lucid64_pkg::*;
#(
    parameter int MULDIV_CYCLES = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  imem_ready_i,
    input  logic                  ld_use_hazard_i,
    input  logic                  ex_multicycle_i,
    input  logic                  ex_redirect_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ack_i,
    input  logic                  trap_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] squash_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic                  redirect_o,
    output logic                  redirect_sel_o
);

    logic         mem_wait_q, mem_wait_d;
    logic         dmemWait;
    logic         exBusy;
    logic         exStalled;
    logic         branchAccept;
    redir_state_e state_q, state_d;

    assign dmemWait     = (dmem_req_i || mem_wait_q) && !dmem_ack_i;
    assign mem_wait_d   = dmem_ack_i ? 1'b0 : (dmem_req_i ? 1'b1 : mem_wait_q);
    assign exStalled    = dmemWait || exBusy;
    assign branchAccept = ex_redirect_i && !exStalled;

    ex_occupancy_counter #(
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) u_ex_occupancy (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .multicycle_i(ex_multicycle_i),
        .mem_stall_i (dmemWait),
        .flush_i     (trap_i),
        .busy_o      (exBusy)
    );

    // Highest active stall level k holds stages 0..k and injects a bubble into stage k+1.
    always_comb begin
        stall_o  = '0;
        bubble_o = '0;
        if (dmemWait) begin
            stall_o  = 5'b01111;
            bubble_o = 5'b10000;
        end else if (exBusy) begin
            stall_o  = 5'b00111;
            bubble_o = 5'b01000;
        end else if (ld_use_hazard_i) begin
            stall_o  = 5'b00011;
            bubble_o = 5'b00100;
        end else if (!imem_ready_i) begin
            stall_o  = 5'b00001;
            bubble_o = 5'b00010;
        end
        if (!rst_ni) begin
            stall_o  = '0;
            bubble_o = '0;
        end
    end

    // Trap is evaluated last so it overrides any branch redirect decided in the same cycle.
    always_comb begin
        state_d        = state_q;
        squash_o       = '0;
        redirect_o     = 1'b0;
        redirect_sel_o = REDIR_BRANCH;
        if (state_q == REDIR_PENDING) begin
            squash_o[IF_STAGE] = 1'b1;
            if (imem_ready_i) begin
                redirect_o = 1'b1;
                state_d    = REDIR_IDLE;
            end
        end
        if (branchAccept) begin
            squash_o[ID_STAGE:IF_STAGE] = 2'b11;
            if (imem_ready_i) begin
                redirect_o = 1'b1;
                state_d    = REDIR_IDLE;
            end else begin
                state_d = REDIR_PENDING;
            end
        end
        if (trap_i) begin
            squash_o[MEM_STAGE:IF_STAGE] = 4'hF;
            redirect_o                   = 1'b1;
            redirect_sel_o               = REDIR_TRAP;
            state_d                      = REDIR_IDLE;
        end
        if (!rst_ni) begin
            squash_o       = 5'h1F;
            redirect_o     = 1'b0;
            redirect_sel_o = REDIR_BRANCH;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= REDIR_IDLE;
            mem_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_wait_q <= mem_wait_d;
        end
    end

endmodule
